mod_lsu: RTL

Load/store unit between the CPU MEM stage and the loadstore port of the memory controller. It decodes RV32I load/store `funct3` into byte enables, word-aligns the address, shifts store data into byte lanes, and runs the strobe handshake with the controller. It also extracts, sign- or zero-extends returned load data and flags misaligned or illegal accesses without touching memory.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mod_lsu_align.sv | 58 +++++
 rtl/mod_lsu.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: RV32I funct3 codes,
// LSU state encoding and byte-enable templates.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enable templates before shifting into the addressed lane.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mod_lsu_align.sv
// Combinational access decoder: byte enables, fault detection, store-lane
// shifting and load extraction/extension for one funct3/offset pair.
module mod_lsu_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = 4
) (
  input  logic            store_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_raw_i,
  output logic [BE_W-1:0] be_o,
  output logic            fault_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] raw_shift;

  assign wdata_o   = wdata_i << {off_i, 3'b000};
  assign raw_shift = rdata_raw_i >> {off_i, 3'b000};

  // Byte enables plus misalignment/illegal-encoding detection.
  always_comb begin
    be_o    = BE_NONE;
    fault_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: be_o = BE_BYTE << off_i;
      F3_H, F3_HU: begin
        be_o    = BE_HALF << off_i;
        fault_o = off_i[0];
      end
      F3_W: begin
        be_o    = BE_WORD;
        fault_o = (off_i != 2'b00);
      end
      default: fault_o = 1'b1;
    endcase
    if (store_i && (funct3_i == F3_BU || funct3_i == F3_HU)) begin
      fault_o = 1'b1;
    end
  end

  // Extract the addressed byte/half from the lane-shifted word and extend it.
  always_comb begin
    rdata_o = raw_shift;
    case (funct3_i)
      F3_B:    rdata_o = {{(XLEN-8){raw_shift[7]}}, raw_shift[7:0]};
      F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, raw_shift[7:0]};
      F3_H:    rdata_o = {{(XLEN-16){raw_shift[15]}}, raw_shift[15:0]};
      F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, raw_shift[15:0]};
      default: rdata_o = raw_shift;
    endcase
  end

endmodule

// File: rtl/mod_lsu.sv
// Load/store unit: turns a held MEM-stage request into one strobe handshake
// with the memory controller and returns the extended load result.
module mod_lsu
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  logic            req_store_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            fault_o,
  output logic [XLEN-1:0] loadstore_address_o,
  output logic            loadstore_address_stb_o,
  output logic [XLEN-1:0] loadstore_writedata_o,
  output logic            loadstore_writedata_stb_o,
  output logic [BE_W-1:0] loadstore_byteenable_o,
  input  logic [XLEN-1:0] loadstore_readdata_i,
  input  logic            loadstore_stb_i
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic            store_q, store_d;
  logic            astb_q, astb_d;
  logic            wstb_q, wstb_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic [BE_W-1:0] req_be;
  logic            req_fault;
  logic [XLEN-1:0] req_wdata_sh;
  logic [XLEN-1:0] resp_rdata;

  logic [XLEN-1:0] unused_req_rdata;
  logic [BE_W-1:0] unused_resp_be;
  logic            unused_resp_fault;
  logic [XLEN-1:0] unused_resp_wdata;

  // Request side works on the live fields from the MEM stage.
  mod_lsu_align #(.XLEN(XLEN), .BE_W(BE_W)) u_align_req (
    .store_i     (req_store_i),
    .funct3_i    (req_funct3_i),
    .off_i       (req_addr_i[1:0]),
    .wdata_i     (req_wdata_i),
    .rdata_raw_i (loadstore_readdata_i),
    .be_o        (req_be),
    .fault_o     (req_fault),
    .wdata_o     (req_wdata_sh),
    .rdata_o     (unused_req_rdata)
  );

  // Response side works on the fields captured when the access was issued.
  mod_lsu_align #(.XLEN(XLEN), .BE_W(BE_W)) u_align_resp (
    .store_i     (store_q),
    .funct3_i    (funct3_q),
    .off_i       (off_q),
    .wdata_i     (wdata_q),
    .rdata_raw_i (loadstore_readdata_i),
    .be_o        (unused_resp_be),
    .fault_o     (unused_resp_fault),
    .wdata_o     (unused_resp_wdata),
    .rdata_o     (resp_rdata)
  );

  // State and captured-access registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      store_q  <= 1'b0;
      astb_q   <= 1'b0;
      wstb_q   <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      store_q  <= store_d;
      astb_q   <= astb_d;
      wstb_q   <= wstb_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state logic: issue in IDLE, hold strobes in BUSY until the
  // controller pulses, then a single DONE cycle back to IDLE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    store_d  = store_q;
    astb_d   = astb_q;
    wstb_d   = wstb_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_fault) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            fault_d  = 1'b0;
            addr_d   = {req_addr_i[XLEN-1:2], 2'b00};
            be_d     = req_be;
            wdata_d  = req_wdata_sh;
            funct3_d = req_funct3_i;
            off_d    = req_addr_i[1:0];
            store_d  = req_store_i;
            astb_d   = 1'b1;
            wstb_d   = req_store_i;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (loadstore_stb_i) begin
          astb_d  = 1'b0;
          wstb_d  = 1'b0;
          if (!store_q) begin
            rdata_d = resp_rdata;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done_o                    = (state_q == DONE);
  assign fault_o                   = done_o && fault_q;
  assign stall_o                   = req_valid_i && !done_o;
  assign rdata_o                   = rdata_q;
  assign loadstore_address_o       = addr_q;
  assign loadstore_address_stb_o   = astb_q;
  assign loadstore_writedata_o     = wdata_q;
  assign loadstore_writedata_stb_o = wstb_q;
  assign loadstore_byteenable_o    = be_q;

endmodule
